branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
Parametrised branch target buffer with saturating-counter direction prediction. It is the next-generation replacement for the ID-stage resolve-and-flush branch scheme.
- IF performs a same-cycle lookup on the fetch PC.
- ID reports resolved branch/jump outcomes back as updates.
- A hardware clear sweep runs after reset or on request, and built-in saturating statistics counters track updates and mispredicts.

Parameters:
PC_WIDTH, 32, width of PC and target addresses
INDEX_BITS, 4, log2 of entry count (ENTRIES = 2**INDEX_BITS); index = pc[INDEX_BITS+1:2]
COUNTER_BITS, 2, width of per-entry saturating direction counter (>=1)
STAT_WIDTH, 16, width of statistics counters

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush_all  input  1  request a full table clear (sweep)
lookup_pc  input  PC_WIDTH  fetch PC from IF
predict_hit  output  1  valid entry with matching tag at lookup_pc
predict_taken  output  1  hit && counter MSB set
predict_target  output  PC_WIDTH  stored target when hit, else 0
update_valid  input  1  one resolved control-flow instruction this cycle
update_pc  input  PC_WIDTH  PC of resolved instruction
update_taken  input  1  actual direction
update_target  input  PC_WIDTH  actual target
update_predicted  input  1  predict_taken value carried down the pipe with that instruction
busy  output  1  clear sweep in progress
stat_updates  output  STAT_WIDTH  accepted updates, saturating
stat_mispredicts  output  STAT_WIDTH  accepted updates with update_taken != update_predicted, saturating

Behaviour:
Entry layout: valid, tag = pc[PC_WIDTH-1:INDEX_BITS+2], counter, target.

Lookup:
- Combinational read of the table state.
- predict_* = 0 whenever busy=1.

Table writes:
- Synchronous; visible from the next cycle.
- A same-cycle lookup and update to the same index returns the pre-update contents.

Update rules (applied only when update_valid && !busy):
- Hit, taken: counter +1 saturating at 2**COUNTER_BITS-1; target <= update_target.
- Hit, not taken: counter -1 saturating at 0; target unchanged.
- Miss, taken: allocate/replace entry. Set valid=1, new tag, counter = 2**(COUNTER_BITS-1) (weakly taken), target = update_target.
- Miss, not taken: no table change.
- Statistics: stat_updates +1. stat_mispredicts +1 if update_taken != update_predicted. Both saturate at all-ones.
- update_valid while busy is ignored: no table write, no stat change.

FSM:
- States:
  - CLEAR: busy=1. idx counter walks 0..ENTRIES-1, clearing one entry per cycle (valid=0, counter=0, target=0).
  - READY: busy=0. Lookups and updates are served.
- Transitions:
  - reset -> CLEAR with idx=0.
  - CLEAR -> READY on the cycle idx==ENTRIES-1 is cleared. CLEAR lasts exactly ENTRIES cycles.
  - READY -> CLEAR on flush_all, with idx=0. Any update in that same cycle is dropped.
  - flush_all during CLEAR restarts idx at 0.
- reset mid-sweep restarts the sweep.

Reset values:
- busy=1; stat_updates=0, stat_mispredicts=0; predict_hit=0, predict_taken=0, predict_target=0.
- flush_all does not clear the statistics.

Test Plan:
- Reset held 1 cycle, ENTRIES=16 -> busy=1 for exactly 16 cycles then 0. Every lookup during the sweep returns hit=0, taken=0, target=0. Stats=0.
- After the sweep: update pc=0x40, taken=1, target=0x100, predicted=0 -> next cycle, lookup 0x40 gives hit=1, taken=1, target=0x100. stat_updates=1, stat_mispredicts=1.
- Same PC with three more updates (not-taken, not-taken, taken) -> counter 2→1→0→1. predict_taken reads 0, 0, 0 after each. Stats track 4 updates.
- Alias test: update pc=0x40 taken, then pc=0x440 (same index, different tag) taken with target 0x200 -> lookup 0x40 misses; 0x440 hits with target 0x200. A not-taken miss at pc=0x80 allocates nothing.
- Four taken updates to 0x40 -> counter saturates at 3. One not-taken -> counter 2, predict_taken stays 1. Same-cycle lookup+update to the same index returns old data.
- Mid-run flush_all with a concurrent update -> update dropped, stats unchanged, 16-cycle sweep, all lookups miss afterwards. Stats retained.
- Force stat_mispredicts to 0xFFFF (STAT_WIDTH=16) plus one more mispredict -> value stays 0xFFFF.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// A clear sweep runs after reset or flush_all; statistics counters saturate at all-ones.
module branch_predictor_btb #(
  parameter int PC_WIDTH     = 32,
  parameter int INDEX_BITS   = 4,
  parameter int COUNTER_BITS = 2,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_all,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  predict_hit,
  output logic                  predict_taken,
  output logic [PC_WIDTH-1:0]   predict_target,
  input  logic                  update_valid,
  input  logic [PC_WIDTH-1:0]   update_pc,
  input  logic                  update_taken,
  input  logic [PC_WIDTH-1:0]   update_target,
  input  logic                  update_predicted,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] stat_updates,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

  localparam logic [INDEX_BITS-1:0]   LAST_IDX = INDEX_BITS'(ENTRIES - 1);
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1) << (COUNTER_BITS - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef struct packed {
    logic                    valid;
    logic [TAG_W-1:0]        tag;
    logic [COUNTER_BITS-1:0] ctr;
    logic [PC_WIDTH-1:0]     target;
  } entry_t;

  entry_t btb_q [ENTRIES];

  logic [0:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [STAT_WIDTH-1:0] stat_updates_q, stat_updates_d;
  logic [STAT_WIDTH-1:0] stat_mispredicts_q, stat_mispredicts_d;

  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  entry_t                entry_d;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]      lk_tag, up_tag;
  entry_t                lk_entry, up_entry;
  logic                  lk_hit, up_hit;

  // The two byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign busy     = (state_q == ST_CLEAR);
  assign lk_idx   = lookup_pc[INDEX_BITS+1:2];
  assign lk_tag   = lookup_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign lk_entry = btb_q[lk_idx];
  assign lk_hit   = !busy && lk_entry.valid && (lk_entry.tag == lk_tag);

  assign predict_hit    = lk_hit;
  assign predict_taken  = lk_hit && lk_entry.ctr[COUNTER_BITS-1];
  assign predict_target = lk_hit ? lk_entry.target : '0;

  assign up_idx   = update_pc[INDEX_BITS+1:2];
  assign up_tag   = update_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign up_entry = btb_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    wr_en              = 1'b0;
    wr_idx             = up_idx;
    entry_d            = up_entry;

    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        entry_d = '0;
        if (flush_all) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        if (flush_all) begin
          // A flush wins over a concurrent update, which is dropped entirely.
          state_d = ST_CLEAR;
          idx_d   = '0;
        end else if (update_valid) begin
          if (stat_updates_q != '1) stat_updates_d = stat_updates_q + 1'b1;
          if ((update_taken != update_predicted) && (stat_mispredicts_q != '1))
            stat_mispredicts_d = stat_mispredicts_q + 1'b1;

          if (up_hit) begin
            wr_en = 1'b1;
            if (update_taken) begin
              if (up_entry.ctr != '1) entry_d.ctr = up_entry.ctr + 1'b1;
              entry_d.target = update_target;
            end else if (up_entry.ctr != '0) begin
              entry_d.ctr = up_entry.ctr - 1'b1;
            end
          end else if (update_taken) begin
            wr_en          = 1'b1;
            entry_d.valid  = 1'b1;
            entry_d.tag    = up_tag;
            entry_d.ctr    = CTR_WEAK;
            entry_d.target = update_target;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= ST_CLEAR;
      idx_q              <= '0;
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  // NOTE: the table has no reset branch; the post-reset sweep clears it one entry
  // per cycle and lookups are masked by busy until the sweep completes.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) btb_q[wr_idx] <= entry_d;
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb with hand-computed expectations.
module tb_branch_predictor_btb;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_all;
  logic [31:0] lookup_pc;
  logic        predict_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_predicted;
  logic        busy;
  logic [15:0] stat_updates;
  logic [15:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predictor_btb #(
    .PC_WIDTH(32), .INDEX_BITS(4), .COUNTER_BITS(2), .STAT_WIDTH(16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .flush_all        (flush_all),
    .lookup_pc        (lookup_pc),
    .predict_hit      (predict_hit),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_predicted (update_predicted),
    .busy             (busy),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic pred);
    update_pc        = pc;
    update_taken     = taken;
    update_target    = target;
    update_predicted = pred;
    update_valid     = 1'b1;
    step();
    update_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] target);
    lookup_pc = pc;
    #1;
    check({tag, "_hit"}, 64'(predict_hit), 64'(hit));
    check({tag, "_taken"}, 64'(predict_taken), 64'(taken));
    check({tag, "_target"}, 64'(predict_target), 64'(target));
  endtask

  task automatic check_stats(input string tag, input logic [15:0] upd, input logic [15:0] mis);
    check({tag, "_updates"}, 64'(stat_updates), 64'(upd));
    check({tag, "_mispredicts"}, 64'(stat_mispredicts), 64'(mis));
  endtask

  initial begin
    reset            = 1'b1;
    flush_all        = 1'b0;
    lookup_pc        = 32'h40;
    update_valid     = 1'b0;
    update_pc        = '0;
    update_taken     = 1'b0;
    update_target    = '0;
    update_predicted = 1'b0;
    step();
    reset = 1'b0;

    check_stats("reset", 16'd0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      check("sweep_busy", 64'(busy), 64'd1);
      check("sweep_hit", 64'(predict_hit), 64'd0);
      check("sweep_target", 64'(predict_target), 64'd0);
      step();
    end
    check("sweep_done", 64'(busy), 64'd0);
    look("post_sweep", 32'h40, 1'b0, 1'b0, 32'h0);

    // Allocate, then walk the counter 2 -> 1 -> 0 -> 1.
    do_update(32'h40, 1'b1, 32'h100, 1'b0);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    check_stats("alloc", 16'd1, 16'd1);
    do_update(32'h40, 1'b0, 32'h0, 1'b1);
    look("ctr1", 32'h40, 1'b1, 1'b0, 32'h100);
    do_update(32'h40, 1'b0, 32'h0, 1'b0);
    look("ctr0", 32'h40, 1'b1, 1'b0, 32'h100);
    do_update(32'h40, 1'b1, 32'h100, 1'b0);
    look("ctr1b", 32'h40, 1'b1, 1'b0, 32'h100);
    check_stats("four_updates", 16'd4, 16'd3);

    // Aliasing at index 0.
    do_update(32'h40, 1'b1, 32'h100, 1'b0);
    do_update(32'h440, 1'b1, 32'h200, 1'b0);
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h440, 1'b1, 1'b1, 32'h200);
    do_update(32'h80, 1'b0, 32'h300, 1'b0);
    look("nt_miss", 32'h80, 1'b0, 1'b0, 32'h0);
    look("nt_keep", 32'h440, 1'b1, 1'b1, 32'h200);
    check_stats("alias", 16'd7, 16'd5);

    // Saturation: allocate then three more taken updates, then one not-taken.
    do_update(32'h40, 1'b1, 32'h100, 1'b0);
    do_update(32'h40, 1'b1, 32'h100, 1'b1);
    do_update(32'h40, 1'b1, 32'h100, 1'b1);
    do_update(32'h40, 1'b1, 32'h180, 1'b1);
    do_update(32'h40, 1'b0, 32'h0, 1'b1);
    look("sat", 32'h40, 1'b1, 1'b1, 32'h180);
    check_stats("sat", 16'd12, 16'd7);

    // Same-cycle lookup and update to the same index shows pre-update contents.
    update_pc        = 32'h40;
    update_taken     = 1'b0;
    update_target    = 32'h0;
    update_predicted = 1'b1;
    update_valid     = 1'b1;
    look("bypass_old", 32'h40, 1'b1, 1'b1, 32'h180);
    step();
    update_valid = 1'b0;
    look("bypass_new", 32'h40, 1'b1, 1'b0, 32'h180);
    check_stats("bypass", 16'd13, 16'd8);

    // Flush with a concurrent update: update dropped, stats retained.
    flush_all        = 1'b1;
    update_pc        = 32'h440;
    update_taken     = 1'b1;
    update_target    = 32'h500;
    update_predicted = 1'b0;
    update_valid     = 1'b1;
    step();
    flush_all    = 1'b0;
    update_valid = 1'b0;
    check_stats("flush_drop", 16'd13, 16'd8);
    for (int i = 0; i < 16; i++) begin
      check("flush_busy", 64'(busy), 64'd1);
      step();
    end
    check("flush_done", 64'(busy), 64'd0);
    look("flush_miss40", 32'h40, 1'b0, 1'b0, 32'h0);
    look("flush_miss440", 32'h440, 1'b0, 1'b0, 32'h0);
    check_stats("flush_keep", 16'd13, 16'd8);

    // Mispredict counter saturation.
    force dut.stat_mispredicts_q = 16'hFFFF;
    #1;
    release dut.stat_mispredicts_q;
    do_update(32'h40, 1'b1, 32'h100, 1'b0);
    check_stats("stat_sat", 16'd14, 16'hFFFF);
    look("post_sat", 32'h40, 1'b1, 1'b1, 32'h100);

    // Updates while busy are ignored.
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    do_update(32'h40, 1'b1, 32'h100, 1'b0);
    check("busy_ignore_busy", 64'(busy), 64'd1);
    check_stats("busy_ignore", 16'd14, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
